// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets, STATUS
// bit positions, shifter state encoding, plus the CPU ALU opcodes.
package mmio_uart_tx_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CLKDIV = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_MSB = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // A divider of zero is treated as one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-port bus into the UART register window, plus shifter state for
// observation.
interface mmio_uart_tx_if;
  import mmio_uart_tx_pkg::*;

  // write_en is a one-cycle strobe that is always accepted (no ready); reads
  // are continuous and data_out reflects the address one cycle later.
  logic [31:0] address;
  logic [3:0]  width;
  logic        write_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  tx_state_t   state;

  modport master (output address, width, write_en, data_in,
                  input  data_out, state);
  modport slave  (input  address, width, write_en, data_in,
                  output data_out, state);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CLKDIV registers, a byte
// FIFO and an 8N1 shifter with a programmable bit time.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic          clock,
  input  logic          reset_n,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel, byte_ok;
  logic [1:0]    off;
  logic          push_req, pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          ovf_q, ovf_set, ovf_clr, clkdiv_wr;
  logic [15:0]   clkdiv_q;
  logic [31:0]   rd_val;

  tx_state_t     state_q, state_d;
  logic [15:0]   bit_cnt_q, bit_cnt_d, reload;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d, boundary;

  assign sel     = (bus.address[31:4] == BASE_ADDR[31:4]);
  assign off     = bus.address[3:2];
  assign byte_ok = (bus.width == 4'd1) || (bus.width == 4'd4);

  assign push_req  = bus.write_en && sel && (off == OFF_TXDATA) && byte_ok;
  assign ovf_set   = push_req && fifo_full && !pop;
  assign ovf_clr   = bus.write_en && sel && (off == OFF_STATUS) && byte_ok && bus.data_in[ST_OVF];
  assign clkdiv_wr = bus.write_en && sel && (off == OFF_CLKDIV) && (bus.width == 4'd4);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (push_req),
    .pop   (pop),
    .din   (bus.data_in[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A same-cycle overflow outranks a W1C clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ovf_q    <= 1'b0;
      clkdiv_q <= DIV_RESET;
    end else begin
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (clkdiv_wr) clkdiv_q <= bus.data_in[15:0];
    end
  end

  always_comb begin
    rd_val = '0;
    if (sel && (bus.width == 4'd4)) begin
      case (off)
        OFF_STATUS: begin
          rd_val[ST_BUSY]                = (state_q != S_IDLE);
          rd_val[ST_FULL]                = fifo_full;
          rd_val[ST_EMPTY]               = fifo_empty;
          rd_val[ST_OVF]                 = ovf_q;
          rd_val[ST_CNT_MSB:ST_CNT_LSB]  = 5'(fifo_count);
        end
        OFF_CLKDIV: rd_val = {16'd0, clkdiv_q};
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) bus.data_out <= '0;
    else          bus.data_out <= rd_val;
  end

  assign reload   = eff_div(clkdiv_q) - 16'd1;
  assign boundary = (bit_cnt_q == 16'd0);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if ((state_q != S_IDLE) && !boundary) bit_cnt_d = bit_cnt_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_d   = S_START;
          tx_d      = 1'b0;
          sh_d      = fifo_dout;
          bit_cnt_d = reload;
        end
      end
      S_START: if (boundary) begin
        state_d   = S_DATA;
        tx_d      = sh_q[0];
        sh_d      = {1'b0, sh_q[7:1]};
        idx_d     = 3'd0;
        bit_cnt_d = reload;
      end
      S_DATA: if (boundary) begin
        bit_cnt_d = reload;
        if (idx_q == 3'd7) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d  = sh_q[0];
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
        end
      end
      S_STOP: if (boundary) begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_d   = S_START;
          tx_d      = 1'b0;
          sh_d      = fifo_dout;
          bit_cnt_d = reload;
        end else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
    end
  end

  assign tx        = tx_q;
  assign irq       = fifo_empty && (state_q == S_IDLE);
  assign bus.state = state_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO
// overflow and back-to-back behaviour, divider zero and mid-frame reset.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0400;

  logic clock = 1'b0;
  logic reset_n;
  logic tx, irq;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd;
  logic        low_seen;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is sampled at the next posedge.
  task automatic write_reg(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    bus.address  = a;
    bus.width    = w;
    bus.data_in  = d;
    bus.write_en = 1'b1;
    @(negedge clock);
    bus.write_en = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, input logic [3:0] w, output logic [31:0] v);
    bus.address  = a;
    bus.width    = w;
    bus.write_en = 1'b0;
    @(negedge clock);
    v = bus.data_out;
  endtask

  // Expected line level at sample k of a stream of 8N1 frames from exp_q.
  function automatic logic exp_tx(input int k, input int div);
    int sym, b, pos;
    sym = k / div;
    b   = sym / 10;
    pos = sym % 10;
    if (b >= exp_q.size()) return 1'b1;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return exp_q[b][pos-1];
  endfunction

  task automatic check_stream(input string name, input int first_k, input int last_k, input int div);
    for (int k = first_k; k <= last_k; k++) begin
      if (k != first_k) @(negedge clock);
      check($sformatf("%s_tx%0d", name, k), {31'd0, tx}, {31'd0, exp_tx(k, div)});
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (irq !== 1'b1 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'd0, irq}, 32'h1);
  endtask

  initial begin
    bus.address  = BASE;
    bus.width    = 4'd4;
    bus.data_in  = 32'h0000_00AA;
    bus.write_en = 1'b1;
    reset_n      = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", {31'd0, tx}, 32'h1);
    check("rst_irq", {31'd0, irq}, 32'h1);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_state", 32'(bus.state), 32'(S_IDLE));
    bus.write_en = 1'b0;
    reset_n      = 1'b1;

    read_reg(BASE + 32'd4, 4'd4, rd);  check("status_after_rst", rd, 32'h4);
    read_reg(BASE + 32'd8, 4'd4, rd);  check("clkdiv_rst", rd, 32'h10);
    read_reg(BASE + 32'd12, 4'd4, rd); check("reserved_rd", rd, 32'h0);
    read_reg(BASE + 32'd16, 4'd4, rd); check("outside_rd", rd, 32'h0);
    read_reg(BASE + 32'd8, 4'd1, rd);  check("width1_rd", rd, 32'h0);

    write_reg(BASE, 4'd2, 32'h11);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("txdata_w2_ignored", rd, 32'h4);
    write_reg(BASE + 32'd8, 4'd1, 32'h7);
    read_reg(BASE + 32'd8, 4'd4, rd);  check("clkdiv_w1_ignored", rd, 32'h10);
    write_reg(BASE + 32'd12, 4'd4, 32'hFFFF_FFFF);
    read_reg(BASE + 32'd12, 4'd4, rd); check("reserved_wr", rd, 32'h0);

    write_reg(BASE + 32'd8, 4'd4, 32'hDEAD_0004);
    read_reg(BASE + 32'd8, 4'd4, rd);  check("clkdiv_4", rd, 32'h4);

    // Single frame 0x55 at 4 cycles per bit.
    exp_q.delete();
    exp_q.push_back(8'h55);
    write_reg(BASE, 4'd4, 32'hABCD_EF55);
    check("irq_queued", {31'd0, irq}, 32'h0);
    @(negedge clock);
    check_stream("f55", 0, 39, 4);
    @(negedge clock);
    check("f55_irq_end", {31'd0, irq}, 32'h1);

    // Three frames back to back, no idle gap between STOP and START.
    exp_q.delete();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h81);
    write_reg(BASE, 4'd4, 32'h3C);
    write_reg(BASE, 4'd4, 32'hC3);
    write_reg(BASE, 4'd1, 32'h81);
    check_stream("b2b", 1, 119, 4);
    @(negedge clock);
    check("b2b_irq_end", {31'd0, irq}, 32'h1);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("b2b_status_end", rd, 32'h4);

    // Ten writes while idle: one in flight, eight queued, tenth dropped.
    for (int i = 0; i < 10; i++) write_reg(BASE, 4'd4, 32'hA0 + i);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("ovf_status", rd, 32'h8B);
    write_reg(BASE + 32'd4, 4'd4, 32'h8);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("ovf_cleared", rd, 32'h83);
    wait_idle("ovf_drain", 1000);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("ovf_drain_status", rd, 32'h4);

    // Full FIFO: write exactly on the STOP->START pop edge is accepted.
    for (int i = 0; i < 9; i++) write_reg(BASE, 4'd4, 32'h50 + i);
    repeat (31) @(negedge clock);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("full_before_pop", rd, 32'h83);
    write_reg(BASE, 4'd4, 32'h77);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("full_push_pop", rd, 32'h83);
    write_reg(BASE, 4'd4, 32'h78);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("full_no_pop_ovf", rd, 32'h8B);
    write_reg(BASE + 32'd4, 4'd1, 32'h8);
    wait_idle("full_drain", 2000);
    read_reg(BASE + 32'd4, 4'd4, rd);  check("full_drain_status", rd, 32'h4);

    // Divider zero behaves as one cycle per bit.
    write_reg(BASE + 32'd8, 4'd4, 32'h0);
    read_reg(BASE + 32'd8, 4'd4, rd);  check("clkdiv_0", rd, 32'h0);
    exp_q.delete();
    exp_q.push_back(8'h0F);
    write_reg(BASE, 4'd4, 32'h0F);
    @(negedge clock);
    check_stream("div0", 0, 9, 1);
    @(negedge clock);
    check("div0_irq_end", {31'd0, irq}, 32'h1);

    // Reset during data bit 3 of an all-zero frame with a second byte queued.
    write_reg(BASE + 32'd8, 4'd4, 32'h4);
    write_reg(BASE, 4'd4, 32'h00);
    write_reg(BASE, 4'd4, 32'h00);
    repeat (17) @(negedge clock);
    check("mid_bit3_tx", {31'd0, tx}, 32'h0);
    check("mid_bit3_state", 32'(bus.state), 32'(S_DATA));
    reset_n = 1'b0;
    @(negedge clock);
    check("abort_tx", {31'd0, tx}, 32'h1);
    check("abort_state", 32'(bus.state), 32'(S_IDLE));
    reset_n = 1'b1;
    read_reg(BASE + 32'd4, 4'd4, rd);  check("abort_status", rd, 32'h4);
    low_seen = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check("abort_no_frame", {31'd0, low_seen}, 32'h0);
    read_reg(BASE + 32'd8, 4'd4, rd);  check("abort_clkdiv", rd, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
